// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-enabled word memory with a self-initialising
// INIT phase (word[i] = i), single-cycle read latency, one request per cycle
// once READY, and an out-of-range error pulse for indices >= DEPTH.
// The memory array is split into one byte lane per generate iteration. Each
// lane has its own write enable and a registered read port, so every lane maps
// onto a plain block RAM.
module data_memory_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   data_address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    addr_err,
    output logic                    init_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state_reg;
    logic [MEM_AW-1:0]       cnt_reg;
    logic                    init_done_reg;
    logic                    req_ready_reg;
    logic                    read_valid_reg;
    logic                    addr_err_reg;
    logic                    rd_zero_reg;

    logic [IDX_WIDTH-1:0]    word_index;
    logic                    in_range;
    logic                    accept;
    logic                    rd_accept;
    logic                    wr_accept;
    logic                    init_phase;
    logic [MEM_AW-1:0]       ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [NUM_BYTES-1:0]    lane_we;
    logic [DATA_WIDTH-1:0]   lane_q;
    logic                    addr_offset_unused;

    // The two low address bits select a byte within a word and carry no
    // meaning for a word-wide access.
    assign addr_offset_unused = ^data_address[1:0];

    assign word_index = data_address[ADDR_WIDTH-1:2];
    assign in_range   = 32'(word_index) < DEPTH;

    assign accept     = req_valid & req_ready_reg;
    assign rd_accept  = accept & ~write_en;
    assign wr_accept  = accept & write_en & in_range;
    assign init_phase = (state_reg == ST_INIT);

    // In INIT the counter owns the single RAM port. Requests are never
    // accepted there, so the two users cannot collide.
    assign ram_addr  = init_phase ? cnt_reg : word_index[MEM_AW-1:0];
    assign ram_wdata = init_phase ? DATA_WIDTH'(cnt_reg) : write_data;

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            assign lane_we[gi] = init_phase | (wr_accept & byte_en[gi]);

            // Byte lane write: init pattern or a masked request write.
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[ram_addr] <= ram_wdata[gi*8 +: 8];
                end
            end

            // Registered read. The old value is held between reads, and a
            // write followed by a read one cycle later sees the new data.
            always_ff @(posedge clk) begin
                if (rd_accept) begin
                    lane_q[gi*8 +: 8] <= lane_mem[ram_addr];
                end
            end
        end
    endgenerate

    // Control FSM: INIT walks every word once, then READY persists until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
            req_ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (cnt_reg == LAST_WORD) begin
                        state_reg     <= ST_READY;
                        cnt_reg       <= '0;
                        init_done_reg <= 1'b1;
                        req_ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_READY: begin
                    state_reg     <= ST_READY;
                    init_done_reg <= 1'b1;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_INIT;
                    cnt_reg       <= '0;
                    init_done_reg <= 1'b0;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Response pulses. rd_zero_reg forces read_data to 0 after reset and after
    // an out-of-range read, so the RAM output register needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_valid_reg <= 1'b0;
            addr_err_reg   <= 1'b0;
            rd_zero_reg    <= 1'b1;
        end else begin
            read_valid_reg <= rd_accept;
            addr_err_reg   <= accept & ~in_range;
            if (rd_accept) begin
                rd_zero_reg <= ~in_range;
            end
        end
    end

    assign read_data  = rd_zero_reg ? '0 : lane_q;
    assign read_valid = read_valid_reg;
    assign addr_err   = addr_err_reg;
    assign req_ready  = req_ready_reg;
    assign init_done  = init_done_reg;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Testbench for data_memory_pipe. Directed requests push their expected
// responses into a scoreboard queue. A negedge monitor pops and compares each
// response the DUT presents, and checks that read_data holds between responses.
module tb_data_memory_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        write_en;
    logic [14:0] data_address;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic [31:0] read_data;
    logic        read_valid;
    logic        addr_err;
    logic        init_done;

    typedef struct {
        logic        v;
        logic        e;
        logic [31:0] d;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_data = 32'h0;

    always #5 clk = ~clk;

    data_memory_pipe #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(15),
        .DEPTH(256)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .write_en(write_en),
        .data_address(data_address),
        .write_data(write_data),
        .byte_en(byte_en),
        .read_data(read_data),
        .read_valid(read_valid),
        .addr_err(addr_err),
        .init_done(init_done)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one request for one clock, queueing its expected response.
    task automatic issue(input logic we, input logic [14:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic exp_v, input logic exp_e,
                         input logic [31:0] exp_d, input string nm);
        req_valid    = 1'b1;
        write_en     = we;
        data_address = a;
        write_data   = wd;
        byte_en      = be;
        if (exp_v || exp_e) sb.push_back('{exp_v, exp_e, exp_d, nm});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        write_en  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_rdata"}, read_data, 32'h0);
        check({nm, "_rvalid"}, 32'(read_valid), 32'h0);
        check({nm, "_aerr"}, 32'(addr_err), 32'h0);
        check({nm, "_ready"}, 32'(req_ready), 32'h0);
        check({nm, "_idone"}, 32'(init_done), 32'h0);
    endtask

    // Count INIT cycles (req_ready low) after release, bounded.
    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_cycles"}, 32'(n), 32'd256);
        check({nm, "_idone"}, 32'(init_done), 32'h1);
        $display("init %s: ready after %0d cycles", nm, n);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = 32'h0;
        end else if (read_valid || addr_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got valid=%b err=%b data=%h required none",
                         read_valid, addr_err, read_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, "_valid"}, 32'(read_valid), 32'(e.v));
                check({e.nm, "_err"}, 32'(addr_err), 32'(e.e));
                if (e.v) begin
                    check({e.nm, "_data"}, read_data, e.d);
                    last_data = e.d;
                end else begin
                    check({e.nm, "_hold"}, read_data, last_data);
                end
                $display("txn %s: valid=%b err=%b data=%h", e.nm, read_valid, addr_err, read_data);
            end
        end else begin
            check("hold", read_data, last_data);
        end
    end

    initial begin
        rst_n        = 1'b1;
        req_valid    = 1'b1;
        write_en     = 1'b0;
        data_address = 15'h000;
        write_data   = 32'h0;
        byte_en      = 4'h0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        // req_valid is held high throughout INIT and must be ignored.
        wait_init("init1");

        // Reads of the init pattern, back to back.
        issue(1'b0, 15'h000, 32'h0, 4'h0, 1'b1, 1'b0, 32'd0,   "rd_000");
        issue(1'b0, 15'h004, 32'h0, 4'h0, 1'b1, 1'b0, 32'd1,   "rd_004");
        issue(1'b0, 15'h3FC, 32'h0, 4'h0, 1'b1, 1'b0, 32'd255, "rd_3fc");
        // Masked write, then read back.
        issue(1'b1, 15'h010, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'h0, "wr_010");
        issue(1'b0, 15'h010, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00BB00DD, "rd_010");
        // Out of range read and write, then no aliasing onto word 0 or 255.
        issue(1'b0, 15'h400, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, "rd_400");
        issue(1'b1, 15'h400, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0, "wr_400");
        issue(1'b0, 15'h3FC, 32'h0, 4'h0, 1'b1, 1'b0, 32'd255, "rd_3fc_b");
        issue(1'b0, 15'h000, 32'h0, 4'h0, 1'b1, 1'b0, 32'd0,   "rd_000_b");
        // Write followed immediately by read, and a read with low bits set.
        issue(1'b1, 15'h020, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0, "wr_020");
        issue(1'b0, 15'h020, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678, "rd_020");
        issue(1'b0, 15'h022, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678, "rd_022");
        // Upper byte lanes only, then the highest address.
        issue(1'b1, 15'h024, 32'hCAFEBABE, 4'b1010, 1'b0, 1'b0, 32'h0, "wr_024");
        issue(1'b0, 15'h027, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCA00BA09, "rd_024");
        issue(1'b0, 15'h7FFC, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, "rd_7ffc");
        issue(1'b0, 15'h024, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCA00BA09, "rd_024_b");
        idle(3);
        check("drain1", 32'(sb.size()), 32'd0);

        // Reset while a read response is on the outputs.
        req_valid    = 1'b1;
        write_en     = 1'b0;
        data_address = 15'h3FC;
        @(posedge clk);
        #1;
        check("pre_rst_rvalid", 32'(read_valid), 32'h1);
        check("pre_rst_rdata", read_data, 32'd255);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1 check_reset_outputs("rst_ready");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset again in the middle of INIT.
        repeat (100) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_init");
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_init("init2");

        // INIT rewrote the words that were modified earlier.
        issue(1'b0, 15'h010, 32'h0, 4'h0, 1'b1, 1'b0, 32'd4, "rd_010_re");
        issue(1'b0, 15'h020, 32'h0, 4'h0, 1'b1, 1'b0, 32'd8, "rd_020_re");
        idle(3);
        check("drain2", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 The block SHALL provide parameter ADDR_WIDTH, default 15, byte-address width.
REQ-003 The block SHALL provide parameter DEPTH, default 256, number of words (at most 2^(ADDR_WIDTH-2)).
REQ-004 The block SHALL provide port clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 The block SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL provide port req_valid  input  1  request present.
REQ-007 The block SHALL provide port req_ready  output  1  block can accept a request this cycle.
REQ-008 The block SHALL provide port write_en  input  1  1 = write request, 0 = read request.
REQ-009 The block SHALL provide port data_address  input  ADDR_WIDTH  byte address; word index = data_address[ADDR_WIDTH-1:2].
REQ-010 The block SHALL provide port write_data  input  DATA_WIDTH  write payload.
REQ-011 The block SHALL provide port byte_en  input  DATA_WIDTH/8  per-byte write mask.
REQ-012 The block SHALL provide port read_data  output  DATA_WIDTH  registered read result.
REQ-013 The block SHALL provide port read_valid  output  1  one-cycle pulse qualifying read_data.
REQ-014 The block SHALL provide port addr_err  output  1  one-cycle pulse for out-of-range request.
REQ-015 The block SHALL provide port init_done  output  1  high once initialisation has completed.

Function
REQ-016 Storage SHALL be DEPTH words of DATA_WIDTH bits, one read/write access per cycle.
REQ-017 The block SHALL implement states INIT and READY; reset SHALL enter INIT with init counter 0.
REQ-018 In INIT, each cycle SHALL write word[cnt] = cnt (zero-extended), increment cnt; after writing DEPTH-1 the next state SHALL be READY.
REQ-019 INIT SHALL take exactly DEPTH cycles; init_done SHALL rise on the first READY cycle and stay high until reset.
REQ-020 req_ready SHALL be 0 in INIT and 1 in READY; a request is accepted only when req_valid and req_ready are both 1.
REQ-021 req_valid in INIT SHALL be ignored (no memory change, no response).
REQ-022 Accepted read: read_data SHALL equal word[index] one cycle later with read_valid=1 for exactly that cycle.
REQ-023 Accepted write: each byte b with byte_en[b]=1 SHALL be updated from write_data; masked bytes SHALL be unchanged; read_valid SHALL stay 0.
REQ-024 A read accepted in the cycle after a write to the same index SHALL return the newly written data.
REQ-025 read_data SHALL hold its last value when read_valid is 0.
REQ-026 data_address[1:0] SHALL be ignored (no alignment error).
REQ-027 Index >= DEPTH SHALL pulse addr_err one cycle after acceptance; a write SHALL be discarded; a read SHALL return read_data=0 with read_valid=1.
REQ-028 Back-to-back accepted requests SHALL sustain one per cycle with no bubbles.

Reset
REQ-029 rst_n low SHALL immediately force read_data=0, read_valid=0, addr_err=0, req_ready=0, init_done=0, state INIT, cnt=0.
REQ-030 rst_n asserted mid-INIT or mid-READY SHALL restart INIT from cnt 0; pending responses SHALL be dropped.
REQ-031 Memory contents need not be cleared asynchronously; INIT rewrites every word.

Verification
REQ-032 Release reset, hold req_valid=1 -> req_ready=0 for 256 cycles, init_done=1 and req_ready=1 on cycle 257.
REQ-033 After init, read addresses 0x000, 0x004, 0x3FC -> read_data 0, 1, 255 each one cycle later, read_valid pulses.
REQ-034 Write 0xAABBCCDD to 0x010 with byte_en=4'b0101, then read 0x010 -> read_data 0x00BB00DD.
REQ-035 Read 0x400 (index 256) -> addr_err=1, read_valid=1, read_data=0; write 0x400 then read 0x3FC -> 255 (no aliasing).
REQ-036 Write 0x12345678 to 0x020 then read 0x020 next cycle -> 0x12345678; read 0x022 -> same word.
REQ-037 Assert rst_n=0 at init cycle 100 -> outputs zero immediately; after release init takes full 256 cycles again.
